// File: rtl/fp_preload_sequencer.sv
// fp_preload_sequencer: command-driven preload of the FP register file and imem, then a stall-gated run with retire/timeout accounting
module fp_preload_sequencer #(
  parameter int XLEN = 32,
  parameter int NUM_REGS = 32,
  parameter int IMEM_DEPTH = 64,
  parameter int CNT_W = 16,
  parameter int TIMEOUT = 1000,
  localparam int RA_W = $clog2(NUM_REGS),
  localparam int IA_W = $clog2(IMEM_DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [1:0]      cmd_target,
  input  logic [7:0]      cmd_addr,
  input  logic [XLEN-1:0] cmd_data,
  output logic            rf_we,
  output logic [RA_W-1:0] rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic            imem_we,
  output logic [IA_W-1:0] imem_waddr,
  output logic [XLEN-1:0] imem_wdata,
  output logic            stall,
  input  logic            wb_valid,
  input  logic            wb_reg_write_en,
  output logic [CNT_W-1:0] retired,
  output logic [CNT_W-1:0] cycles,
  output logic            done,
  output logic            timeout,
  output logic            err
);
  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);
  state_t state, state_n;
  logic [CNT_W-1:0] expected, ret_inc;
  logic acc, is_reg, is_imem, is_start, is_abort, reg_ok, imem_ok, bad;
  logic running, hit, fin, tmo, zero_start;
  assign acc        = cmd_valid & cmd_ready;
  assign is_reg     = acc && cmd_target == 2'b00;
  assign is_imem    = acc && cmd_target == 2'b01;
  assign is_start   = acc && cmd_target == 2'b10;
  assign is_abort   = acc && cmd_target == 2'b11;
  assign reg_ok     = state == IDLE && is_reg && int'(cmd_addr) < NUM_REGS;
  assign imem_ok    = state == IDLE && is_imem && int'(cmd_addr) < IMEM_DEPTH;
  assign bad        = state == IDLE ? (is_reg | is_imem) & !(reg_ok | imem_ok) : acc & !is_abort;
  assign running    = state == RUN && !is_abort;
  assign hit        = wb_valid & wb_reg_write_en;
  assign ret_inc    = &retired ? retired : retired + CNT_W'(1);
  assign fin        = running && hit && ret_inc == expected;
  // completion has priority over a timeout landing on the same cycle
  assign tmo        = running && !fin && cycles == LAST;
  assign zero_start = cmd_data[CNT_W-1:0] == '0;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = is_start ? (zero_start ? HALT : RUN) : IDLE;
      RUN:     state_n = is_abort ? IDLE : (fin | tmo) ? HALT : RUN;
      HALT:    state_n = is_abort ? IDLE : HALT;
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
    stall     = state != RUN;
    cmd_ready = 1'b1;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rf_we      <= 1'b0;
      rf_waddr   <= '0;
      rf_wdata   <= '0;
      imem_we    <= 1'b0;
      imem_waddr <= '0;
      imem_wdata <= '0;
      expected   <= '0;
      retired    <= '0;
      cycles     <= '0;
      done       <= 1'b0;
      timeout    <= 1'b0;
      err        <= 1'b0;
    end else begin
      rf_we   <= reg_ok;
      imem_we <= imem_ok;
      if (reg_ok) begin
        rf_waddr <= cmd_addr[RA_W-1:0];
        rf_wdata <= cmd_data;
      end
      if (imem_ok) begin
        imem_waddr <= cmd_addr[IA_W-1:0];
        imem_wdata <= cmd_data;
      end
      if (state == IDLE && is_start) begin
        expected <= cmd_data[CNT_W-1:0];
        retired  <= '0;
        cycles   <= '0;
        done     <= zero_start;
        timeout  <= 1'b0;
      end
      if (running) begin
        if (hit) retired <= ret_inc;
        if (cycles != LAST && !(&cycles)) cycles <= cycles + CNT_W'(1);
        done    <= fin;
        timeout <= tmo;
      end
      if (is_abort) begin
        done    <= 1'b0;
        timeout <= 1'b0;
      end
      err <= is_abort ? 1'b0 : err | bad;
    end
endmodule

// File: tb/tb_fp_preload_sequencer.sv
// tb_fp_preload_sequencer: scoreboard bench; write strobes and run outcomes are predicted at issue and popped by a monitor
module tb_fp_preload_sequencer;
  localparam int T = 20;
  logic clk = 1'b0, reset = 1'b1;
  logic cmd_valid = 1'b0;
  logic [1:0] cmd_target = '0;
  logic [7:0] cmd_addr = '0;
  logic [31:0] cmd_data = '0;
  logic wb_valid = 1'b0, wb_reg_write_en = 1'b0;
  logic cmd_ready, rf_we, imem_we, stall, done, timeout, err;
  logic [4:0] rf_waddr;
  logic [5:0] imem_waddr;
  logic [31:0] rf_wdata, imem_wdata;
  logic [15:0] retired, cycles;
  fp_preload_sequencer #(.TIMEOUT(T)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_target(cmd_target), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .stall(stall), .wb_valid(wb_valid), .wb_reg_write_en(wb_reg_write_en),
    .retired(retired), .cycles(cycles), .done(done), .timeout(timeout), .err(err)
  );
  always #5 clk = ~clk;
  typedef struct {bit im; logic [7:0] a; logic [31:0] d; int due;} wr_t;
  typedef struct {bit dn; bit to; int r; int c;} run_t;
  wr_t wq[$];
  run_t rq[$];
  wr_t w;
  run_t e;
  int cyc = 0, n_vec = 0, n_bad = 0;
  bit exp_err = 1'b0, prev_fin = 1'b0;
  bit [T-1:0] pat;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  always @(negedge clk) if (!reset) begin
    if (rf_we || imem_we) begin
      if (wq.size() == 0) chk("spurious strobe", {rf_we, imem_we}, 0);
      else begin
        w = wq.pop_front();
        chk("strobe kind", {rf_we, imem_we}, w.im ? 2'b01 : 2'b10);
        chk("strobe cycle", cyc, w.due);
        chk("waddr", w.im ? 64'(imem_waddr) : 64'(rf_waddr), w.a);
        chk("wdata", w.im ? imem_wdata : rf_wdata, w.d);
      end
    end
    if ((done | timeout) && !prev_fin) begin
      if (rq.size() == 0) chk("spurious run end", {done, timeout}, 0);
      else begin
        e = rq.pop_front();
        chk("done", done, e.dn);
        chk("timeout", timeout, e.to);
        chk("retired", retired, e.r);
        chk("cycles", cycles, e.c);
        chk("stall at end", stall, 1);
      end
    end
    prev_fin <= done | timeout;
  end
  task automatic send(input logic [1:0] t, input logic [7:0] a, input logic [31:0] d, input bit in_idle);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_target = t; cmd_addr = a; cmd_data = d;
    if (t < 2) begin
      if (in_idle && int'(a) < (t == 0 ? 32 : 64)) wq.push_back('{t == 2'b01, a, d, cyc + 1});
      else exp_err = 1'b1;
    end else if (t == 3) exp_err = 1'b0;
    else if (!in_idle) exp_err = 1'b1;
    @(posedge clk);
  endtask
  task automatic idle();
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask
  task automatic abort();
    send(2'b11, 8'd0, 32'd0, 1'b0);
    idle();
    chk("abort done", done, 0);
    chk("abort timeout", timeout, 0);
    chk("abort err", err, 0);
    chk("abort stall", stall, 1);
  endtask
  // reference: walk RUN cycles; finish when retirements reach n, else stop on the T-th cycle
  task automatic run(input int n, input bit [T-1:0] p, input bit inj);
    run_t x;
    int r = 0, k_end = T - 1;
    x = '{0, 0, 0, 0};
    for (int k = 0; k < T; k++) begin
      r += int'(p[k]);
      if (r == n) begin x.dn = 1; k_end = k; break; end
    end
    x.to = !x.dn;
    x.r = r;
    x.c = (k_end + 1 < T - 1) ? k_end + 1 : T - 1;
    rq.push_back(x);
    send(2'b10, 8'd0, 32'(n), 1'b1);
    for (int k = 0; k <= k_end; k++) begin
      @(negedge clk);
      if (k == 0) chk("stall low in run", stall, 0);
      cmd_valid = inj && k == 1;
      cmd_target = 2'b00; cmd_addr = 8'd2;
      if (inj && k == 1) exp_err = 1'b1;
      wb_valid = p[k] ? 1'b1 : 1'($urandom_range(0, 1));
      wb_reg_write_en = p[k];
      @(posedge clk);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    wb_valid = 1'b1; wb_reg_write_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    wb_valid = 1'b0; wb_reg_write_en = 1'b0;
    chk("retired frozen in halt", retired, x.r);
    chk("stall held in halt", stall, 1);
    chk("err after run", err, exp_err);
    chk("run end seen", rq.size(), 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    #12 reset = 1'b0;
    @(negedge clk);
    chk("reset stall", stall, 1);
    chk("reset strobes", {rf_we, imem_we}, 0);
    chk("reset counters", {retired, cycles}, 0);
    chk("reset flags", {done, timeout, err}, 0);
    chk("cmd_ready", cmd_ready, 1);
    send(2'b00, 8'd1, 32'h4048F5C3, 1'b1);
    idle();
    chk("err after reg write", err, 0);
    chk("stall in idle", stall, 1);
    send(2'b01, 8'd3, 32'h18208353, 1'b1);
    send(2'b01, 8'd4, 32'h00418233, 1'b1);
    send(2'b00, 8'd40, 32'hDEADBEEF, 1'b1);
    idle();
    chk("err bad reg addr", err, 1);
    abort();
    run(12, T'(20'h00FFF), 1'b0);
    abort();
    run(5, T'(20'b0000_0000_0100_0100_0001), 1'b0);
    abort();
    run(1, T'(1) << (T - 1), 1'b0);
    abort();
    rq.push_back('{1, 0, 0, 0});
    send(2'b10, 8'd0, 32'hFFFF0000, 1'b1);
    idle();
    for (int i = 0; i < 3; i++) begin
      chk("stall zero start", stall, 1);
      @(negedge clk);
    end
    send(2'b00, 8'd1, 32'h1, 1'b0);
    idle();
    chk("err write in halt", err, 1);
    abort();
    run(6, T'(20'b0101_0101_0101_0101_0110), 1'b1);
    abort();
    for (int it = 0; it < 25; it++) begin
      for (int j = 0; j < $urandom_range(1, 4); j++)
        send(2'($urandom_range(0, 1)), 8'($urandom_range(0, 70)), $urandom, 1'b1);
      idle();
      chk("rand err", err, exp_err);
      pat = T'($urandom);
      run($urandom_range(1, 10), pat, 1'($urandom_range(0, 1)));
      abort();
    end
    send(2'b10, 8'd0, 32'd10, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      wb_valid = 1'b1; wb_reg_write_en = 1'b1;
      @(posedge clk);
    end
    @(negedge clk);
    wb_valid = 1'b0; wb_reg_write_en = 1'b0;
    cmd_valid = 1'b1; cmd_target = 2'b11; exp_err = 1'b0;
    @(posedge clk);
    idle();
    chk("abort run stall", stall, 1);
    chk("abort run retired", retired, 3);
    chk("abort run cycles", cycles, 3);
    chk("abort run flags", {done, timeout, err}, 0);
    send(2'b10, 8'd0, 32'd10, 1'b1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      wb_valid = k < 4; wb_reg_write_en = k < 4;
      @(posedge clk);
    end
    @(negedge clk);
    wb_valid = 1'b0; wb_reg_write_en = 1'b0;
    chk("retired before reset", retired, 4);
    chk("stall before reset", stall, 0);
    #2 reset = 1'b1;
    #1;
    chk("async reset stall", stall, 1);
    chk("async reset counters", {retired, cycles}, 0);
    chk("async reset flags", {done, timeout, err, rf_we, imem_we}, 0);
    reset = 1'b0;
    exp_err = 1'b0;
    @(negedge clk);
    chk("stall after reset", stall, 1);
    chk("write queue drained", wq.size(), 0);
    chk("run queue drained", rq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
